// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared opcodes, FSM states and widths for the shared-ALU arbiter.
package alu_arbiter_pkg;
   localparam int DATA_W = 8;
   typedef enum logic [2:0] {
      OP_FWD = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SUB = 3'b100
   } op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;
endpackage

// File: rtl/alu_arbiter_alu8.sv
// alu8: combinational 8-bit opcode decoder over FORWARD/ADD/AND/OR/SUB units.
// Reserved opcodes yield a zero result and raise err.
module alu8
   import alu_arbiter_pkg::*;
(
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              err
);
   always_comb begin
      err    = op > OP_SUB;
      result = op == OP_FWD ? b :
               op == OP_ADD ? a + b :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_SUB ? a - b : '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin valid/ready front end that time-shares one alu8,
// holding operands ALU_WAIT cycles before registering a tagged response.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int ALU_WAIT = 2
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic [1:0]        REQ_VALID,
   output logic [1:0]        REQ_READY,
   input  logic [2:0]        REQ_OP0,
   input  logic [2:0]        REQ_OP1,
   input  logic [DATA_W-1:0] REQ_A0,
   input  logic [DATA_W-1:0] REQ_A1,
   input  logic [DATA_W-1:0] REQ_B0,
   input  logic [DATA_W-1:0] REQ_B1,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic              RSP_ID,
   output logic [DATA_W-1:0] RSP_RESULT,
   output logic              RSP_ZERO,
   output logic              RSP_ERR
);
   state_e            state, next;
   logic              last, grant, accept, done;
   logic [3:0]        cnt;
   logic [2:0]        hold_op;
   logic [DATA_W-1:0] hold_a, hold_b, alu_res;
   logic              hold_id, alu_err;

   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) state <= S_IDLE;
      else state <= next;

   always_comb begin
      done = state == S_EXEC && cnt == 4'(ALU_WAIT - 1);
      next = state == S_IDLE ? (|REQ_VALID ? S_EXEC : S_IDLE) :
             state == S_EXEC ? (done ? S_RESP : S_EXEC) :
             state == S_RESP ? (RSP_VALID && RSP_READY ? S_IDLE : S_RESP) : S_IDLE;
   end

   // Single valid requester wins outright; a tie goes to whoever did not win last.
   always_comb begin
      grant     = REQ_VALID == 2'b10 ? 1'b1 : REQ_VALID == 2'b01 ? 1'b0 : ~last;
      accept    = state == S_IDLE && |REQ_VALID;
      REQ_READY = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         last    <= 1'b1;
         cnt     <= '0;
         hold_op <= '0;
         hold_a  <= '0;
         hold_b  <= '0;
         hold_id <= 1'b0;
      end else begin
         cnt <= state == S_EXEC && !done ? cnt + 4'd1 : 4'd0;
         if (accept) begin
            last    <= grant;
            hold_id <= grant;
            hold_op <= grant ? REQ_OP1 : REQ_OP0;
            hold_a  <= grant ? REQ_A1 : REQ_A0;
            hold_b  <= grant ? REQ_B1 : REQ_B0;
         end
      end

   alu8 u_alu (
      .op     (hold_op),
      .a      (hold_a),
      .b      (hold_b),
      .result (alu_res),
      .err    (alu_err)
   );

   // Response fields only change when a new result lands, so they hold through backpressure.
   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         RSP_VALID  <= 1'b0;
         RSP_ID     <= 1'b0;
         RSP_RESULT <= '0;
         RSP_ZERO   <= 1'b0;
         RSP_ERR    <= 1'b0;
      end else if (done) begin
         RSP_VALID  <= 1'b1;
         RSP_ID     <= hold_id;
         RSP_RESULT <= alu_res;
         RSP_ZERO   <= alu_res == '0;
         RSP_ERR    <= alu_err;
      end else if (RSP_VALID && RSP_READY) begin
         RSP_VALID <= 1'b0;
      end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, results, backpressure
// and asynchronous reset for alu_arbiter.
module tb_alu_arbiter;
   localparam int W = 2;
   logic       CLK = 1'b0, RESETN = 1'b0, RSP_READY = 1'b1;
   logic [1:0] REQ_VALID = '0, REQ_READY;
   logic [2:0] REQ_OP0 = '0, REQ_OP1 = '0;
   logic [7:0] REQ_A0 = '0, REQ_A1 = '0, REQ_B0 = '0, REQ_B1 = '0, RSP_RESULT;
   logic       RSP_VALID, RSP_ID, RSP_ZERO, RSP_ERR;
   int         checks = 0, failures = 0;
   bit         mon = 1'b0;

   alu_arbiter #(.ALU_WAIT(W)) dut (
      .CLK(CLK), .RESETN(RESETN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_OP0(REQ_OP0), .REQ_OP1(REQ_OP1), .REQ_A0(REQ_A0), .REQ_A1(REQ_A1),
      .REQ_B0(REQ_B0), .REQ_B1(REQ_B1), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_ID(RSP_ID), .RSP_RESULT(RSP_RESULT), .RSP_ZERO(RSP_ZERO), .RSP_ERR(RSP_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK)
      if (mon) chk("ready_both", {31'b0, REQ_READY == 2'b11}, 0);

   // Called a few ns after an edge with the request already driven.
   task automatic do_op(input string tag, input logic id, input logic [7:0] res,
                        input logic z, input logic e, input int hold, input bit drop);
      int n;
      RSP_READY = hold == 0;
      #1 chk({tag, "_grant"}, REQ_READY, id ? 2 : 1);
      @(posedge CLK); #2;
      if (drop) REQ_VALID = 2'b00;
      chk({tag, "_busy"}, REQ_READY, 0);
      n = 0;
      while (!RSP_VALID && n < 20) begin
         @(posedge CLK); #2;
         n++;
      end
      chk({tag, "_latency"}, n, W);
      chk({tag, "_id"}, RSP_ID, id);
      chk({tag, "_result"}, RSP_RESULT, res);
      chk({tag, "_zero"}, RSP_ZERO, z);
      chk({tag, "_err"}, RSP_ERR, e);
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #2;
         chk({tag, "_stall_valid"}, RSP_VALID, 1);
         chk({tag, "_stall_result"}, RSP_RESULT, res);
         chk({tag, "_stall_id"}, RSP_ID, id);
         chk({tag, "_stall_ready"}, REQ_READY, 0);
      end
      RSP_READY = 1'b1;
      @(posedge CLK); #2;
      chk({tag, "_released"}, RSP_VALID, 0);
   endtask

   initial begin
      #1;
      chk("rst_ready", REQ_READY, 0);
      chk("rst_valid", RSP_VALID, 0);
      repeat (3) @(posedge CLK);
      #2 RESETN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #2;
         chk("idle_ready", REQ_READY, 0);
         chk("idle_rsp", {RSP_VALID, RSP_ID, RSP_ZERO, RSP_ERR, RSP_RESULT}, 0);
      end
      // Tie: both requesters held valid across three operations.
      REQ_OP0 = 3'b001; REQ_A0 = 8'hFF; REQ_B0 = 8'h01;
      REQ_OP1 = 3'b100; REQ_A1 = 8'h05; REQ_B1 = 8'h05;
      REQ_VALID = 2'b11;
      mon = 1'b1;
      do_op("tie0", 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
      do_op("tie1", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
      do_op("tie2", 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
      REQ_VALID = 2'b00;
      mon = 1'b0;
      REQ_OP0 = 3'b011; REQ_A0 = 8'hA5; REQ_B0 = 8'h0F; REQ_VALID = 2'b01;
      do_op("or", 1'b0, 8'hAF, 1'b0, 1'b0, 0, 1'b1);
      REQ_OP0 = 3'b001; REQ_A0 = 8'h12; REQ_B0 = 8'h34; REQ_VALID = 2'b01;
      do_op("bp", 1'b0, 8'h46, 1'b0, 1'b0, 5, 1'b0);
      chk("bp_idle_ready", REQ_READY, 1);
      REQ_VALID = 2'b00;
      REQ_OP1 = 3'b110; REQ_A1 = 8'h33; REQ_B1 = 8'h44; REQ_VALID = 2'b10;
      do_op("rsvd", 1'b1, 8'h00, 1'b1, 1'b1, 0, 1'b1);
      REQ_OP1 = 3'b010; REQ_A1 = 8'hF0; REQ_B1 = 8'h3C; REQ_VALID = 2'b10;
      do_op("and", 1'b1, 8'h30, 1'b0, 1'b0, 0, 1'b1);
      REQ_OP1 = 3'b100; REQ_A1 = 8'h03; REQ_B1 = 8'h05; REQ_VALID = 2'b10;
      do_op("sub", 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1'b1);
      REQ_OP0 = 3'b000; REQ_A0 = 8'h11; REQ_B0 = 8'h5A; REQ_VALID = 2'b01;
      do_op("fwd", 1'b0, 8'h5A, 1'b0, 1'b0, 0, 1'b1);
      // Reset one cycle into EXEC; last is 0 here so this tie goes to requester 1.
      REQ_OP0 = 3'b001; REQ_A0 = 8'h01; REQ_B0 = 8'h02;
      REQ_OP1 = 3'b011; REQ_A1 = 8'h0F; REQ_B1 = 8'hF0;
      REQ_VALID = 2'b11;
      #1 chk("mid_grant", REQ_READY, 2);
      @(posedge CLK); #2;
      REQ_VALID = 2'b00;
      @(posedge CLK); #2;
      RESETN = 1'b0;
      #1;
      chk("mid_rst_valid", RSP_VALID, 0);
      chk("mid_rst_result", RSP_RESULT, 0);
      chk("mid_rst_flags", {RSP_ID, RSP_ZERO, RSP_ERR}, 0);
      chk("mid_rst_ready", REQ_READY, 0);
      @(posedge CLK); #2;
      RESETN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #2;
         chk("mid_no_rsp", RSP_VALID, 0);
      end
      REQ_VALID = 2'b11;
      do_op("post_rst_tie", 1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
